// File: rtl/cheat_pgm_loader_if.sv
// MCU byte-stream and engine programming-port signals for cheat_pgm_loader.
// master drives the stream and pgm_block; slave is the loader.
interface cheat_pgm_loader_if;
   logic        frame_start;
   logic [7:0]  mcu_data;
   logic        mcu_valid;
   logic        mcu_ready;
   logic        pgm_block;
   logic [2:0]  pgm_idx;
   logic        pgm_we;
   logic [31:0] pgm_in;
   logic        busy;
   logic        done;
   logic        err;

   modport master (
      output frame_start, mcu_data, mcu_valid, pgm_block,
      input  mcu_ready, pgm_idx, pgm_we, pgm_in, busy, done, err
   );

   modport slave (
      input  frame_start, mcu_data, mcu_valid, pgm_block,
      output mcu_ready, pgm_idx, pgm_we, pgm_in, busy, done, err
   );
endinterface

// File: rtl/cheat_pgm_loader.sv
// Frames MCU bytes into single-cycle writes on the cheat engine programming port.
// Define CHEAT_PGM_CHECKSUM_EN to buffer WRITE_WORDS frames and verify a trailing XOR byte.
module cheat_pgm_loader #(
   parameter int MAX_WORDS = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   cheat_pgm_loader_if.slave   pgm_bus
);
   localparam int CW = $clog2(MAX_WORDS);

   typedef enum logic [3:0] {
      S_IDLE, S_HDR, S_DATA, S_WRITE, S_CLR6, S_CLR7, S_FLAG, S_SKIP, S_CHK
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      byte_cnt_q, byte_cnt_d;
   logic [CW-1:0]   words_q, words_d;
   logic [CW-1:0]   ptr_q, ptr_d;
   logic [2:0]      cur_idx_q, cur_idx_d;
   logic [23:0]     word_sr_q, word_sr_d;
   logic [2:0]      pgm_idx_q, pgm_idx_d;
   logic [31:0]     pgm_in_q, pgm_in_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            we_last_q;

   logic            pgm_we_c;
   logic            mcu_ready_c;
   logic            accept;
   logic [31:0]     new_word;

`ifdef CHEAT_PGM_CHECKSUM_EN
   logic [7:0]      chk_q, chk_d;
   logic            src_shd_q, src_shd_d;
   logic            shd_we;
   logic            shd_load;
   logic [CW-1:0]   shd_addr;
   logic [31:0]     shd_rd_q;
   logic [31:0]     shd_mem [MAX_WORDS];
`endif

   assign new_word    = {word_sr_q, pgm_bus.mcu_data};
   assign mcu_ready_c = !pgm_bus.frame_start &&
                        (state_q inside {S_HDR, S_DATA, S_FLAG, S_SKIP, S_CHK});
   assign accept      = pgm_bus.mcu_valid && mcu_ready_c;
   // we_last_q inserts a gap so back-to-back write states never strobe twice in a row
   assign pgm_we_c    = (state_q inside {S_WRITE, S_CLR6, S_CLR7}) && !pgm_bus.pgm_block &&
                        !we_last_q && !pgm_bus.frame_start;

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      words_d    = words_q;
      ptr_d      = ptr_q;
      cur_idx_d  = cur_idx_q;
      word_sr_d  = word_sr_q;
      pgm_idx_d  = pgm_idx_q;
      pgm_in_d   = pgm_in_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;
`ifdef CHEAT_PGM_CHECKSUM_EN
      chk_d      = chk_q;
      src_shd_d  = src_shd_q;
      shd_we     = 1'b0;
      shd_load   = 1'b0;
      shd_addr   = ptr_q;
`endif
      if (pgm_bus.frame_start) begin
         state_d    = S_HDR;
         busy_d     = 1'b1;
         err_d      = 1'b0;
         byte_cnt_d = 2'd0;
`ifdef CHEAT_PGM_CHECKSUM_EN
         src_shd_d  = 1'b0;
`endif
      end else begin
         case (state_q)
            S_HDR: if (accept) begin
               case (pgm_bus.mcu_data[7:6])
                  2'b00: begin
                     cur_idx_d  = pgm_bus.mcu_data[2:0];
                     words_d    = pgm_bus.mcu_data[5:3];
                     ptr_d      = '0;
                     byte_cnt_d = 2'd0;
                     state_d    = S_DATA;
`ifdef CHEAT_PGM_CHECKSUM_EN
                     chk_d      = pgm_bus.mcu_data;
`endif
                  end
                  2'b01: begin
                     pgm_idx_d = 3'd6;
                     pgm_in_d  = 32'h0000_0000;
                     state_d   = S_CLR6;
                  end
                  2'b10: state_d = S_FLAG;
                  default: begin
                     err_d   = 1'b1;
                     state_d = S_SKIP;
                  end
               endcase
            end
            S_DATA: if (accept) begin
               word_sr_d  = new_word[23:0];
               byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef CHEAT_PGM_CHECKSUM_EN
               chk_d = chk_q ^ pgm_bus.mcu_data;
               if (byte_cnt_q == 2'd3) begin
                  shd_we = 1'b1;
                  if (ptr_q == words_q) state_d = S_CHK;
                  else                  ptr_d   = ptr_q + 1'b1;
               end
`else
               if (byte_cnt_q == 2'd3) begin
                  pgm_idx_d = cur_idx_q;
                  pgm_in_d  = new_word;
                  state_d   = S_WRITE;
               end
`endif
            end
            S_WRITE: if (pgm_we_c) begin
               cur_idx_d = cur_idx_q + 3'd1;
               if (ptr_q == words_q) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  ptr_d = ptr_q + 1'b1;
`ifdef CHEAT_PGM_CHECKSUM_EN
                  shd_load  = 1'b1;
                  shd_addr  = ptr_q + 1'b1;
                  pgm_idx_d = cur_idx_q + 3'd1;
`else
                  state_d = S_DATA;
`endif
               end
            end
            S_CLR6: if (pgm_we_c) begin
               pgm_idx_d = 3'd7;
               pgm_in_d  = 32'h0000_00F0;
               state_d   = S_CLR7;
            end
            S_CLR7: if (pgm_we_c) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
            S_FLAG: if (accept) begin
               // reuse the single-word WRITE path for the flag byte
               pgm_idx_d = 3'd7;
               pgm_in_d  = {24'h0, pgm_bus.mcu_data};
               words_d   = '0;
               ptr_d     = '0;
               state_d   = S_WRITE;
            end
`ifdef CHEAT_PGM_CHECKSUM_EN
            S_CHK: if (accept) begin
               if (pgm_bus.mcu_data == chk_q) begin
                  ptr_d     = '0;
                  shd_load  = 1'b1;
                  shd_addr  = '0;
                  pgm_idx_d = cur_idx_q;
                  src_shd_d = 1'b1;
                  state_d   = S_WRITE;
               end else begin
                  err_d   = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         byte_cnt_q <= 2'd0;
         words_q    <= '0;
         ptr_q      <= '0;
         cur_idx_q  <= 3'd0;
         word_sr_q  <= 24'h0;
         pgm_idx_q  <= 3'd0;
         pgm_in_q   <= 32'h0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         we_last_q  <= 1'b0;
`ifdef CHEAT_PGM_CHECKSUM_EN
         chk_q      <= 8'h0;
         src_shd_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         words_q    <= words_d;
         ptr_q      <= ptr_d;
         cur_idx_q  <= cur_idx_d;
         word_sr_q  <= word_sr_d;
         pgm_idx_q  <= pgm_idx_d;
         pgm_in_q   <= pgm_in_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         we_last_q  <= pgm_we_c;
`ifdef CHEAT_PGM_CHECKSUM_EN
         chk_q      <= chk_d;
         src_shd_q  <= src_shd_d;
`endif
      end
   end

`ifdef CHEAT_PGM_CHECKSUM_EN
   // shadow word store: plain RAM with registered read feeding pgm_in
   always_ff @(posedge clk) begin
      if (shd_we)   shd_mem[ptr_q] <= new_word;
      if (shd_load) shd_rd_q       <= shd_mem[shd_addr];
   end
   assign pgm_bus.pgm_in = src_shd_q ? shd_rd_q : pgm_in_q;
`else
   assign pgm_bus.pgm_in = pgm_in_q;
`endif

   assign pgm_bus.mcu_ready = mcu_ready_c;
   assign pgm_bus.pgm_we    = pgm_we_c;
   assign pgm_bus.pgm_idx   = pgm_idx_q;
   assign pgm_bus.busy      = busy_q;
   assign pgm_bus.done      = done_q;
   assign pgm_bus.err       = err_q;
endmodule

// File: tb/tb_cheat_pgm_loader.sv
// Directed bench for cheat_pgm_loader: table of frames with expected writes plus
// hand sequences for blocking, abort and (when CHEAT_PGM_CHECKSUM_EN) checksum cases.
module tb_cheat_pgm_loader;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cheat_pgm_loader_if bus ();

   cheat_pgm_loader #(.MAX_WORDS(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .pgm_bus (bus.slave)
   );

   typedef struct {
      int          nb;
      logic [7:0]  b  [20];
      int          nw;
      logic [2:0]  ei [4];
      logic [31:0] ed [4];
      logic        e_err;
      int          e_done;
   } vec_t;

   vec_t vt [6];

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;
   logic prev_we = 1'b0;
   logic [2:0]  w_idx [$];
   logic [31:0] w_dat [$];

   // write/done monitor; also checks that pgm_we is never high two cycles running
   always @(negedge clk) begin
      if (bus.pgm_we === 1'b1) begin
         w_idx.push_back(bus.pgm_idx);
         w_dat.push_back(bus.pgm_in);
         n_cmp++;
         if (prev_we) begin
            n_bad++;
            $display("FAIL we_consecutive: got pgm_we high twice in a row, want single-cycle");
         end
      end
      prev_we = (bus.pgm_we === 1'b1);
      if (bus.done === 1'b1) done_cnt++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic start_frame();
      @(posedge clk); #1;
      bus.frame_start = 1'b1;
      @(posedge clk); #1;
      bus.frame_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d);
      bit got = 1'b0;
      bus.mcu_data  = d;
      bus.mcu_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (bus.mcu_ready === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: byte %h never accepted", d);
      end
      @(posedge clk); #1;
      bus.mcu_valid = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      bit seen = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk); #1;
         if (done_cnt > d0) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: got no done pulse, want one");
      end
   endtask

   task automatic clear_log();
      w_idx.delete();
      w_dat.delete();
   endtask

   task automatic add_wr(input int v, input logic [2:0] i, input logic [31:0] d);
      vt[v].ei[vt[v].nw] = i;
      vt[v].ed[vt[v].nw] = d;
      vt[v].nw++;
   endtask

   task automatic set_bytes3(input int v, input logic [7:0] a, input logic [7:0] b1,
                             input logic [7:0] c, input logic [7:0] d, input logic [7:0] e,
                             input int n);
      vt[v].b[0] = a; vt[v].b[1] = b1; vt[v].b[2] = c; vt[v].b[3] = d; vt[v].b[4] = e;
      vt[v].nb = n;
   endtask

   initial begin
      int d0;
      logic [7:0] x;

      for (int v = 0; v < 6; v++) begin
         vt[v].nw = 0;
         vt[v].e_err = 1'b0;
         vt[v].e_done = 1;
      end
      set_bytes3(0, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 5);
      add_wr(0, 3'd0, 32'h12345678);
      vt[1].b[0] = 8'h1E;
      for (int i = 1; i <= 16; i++) vt[1].b[i] = 8'(i);
      vt[1].nb = 17;
      add_wr(1, 3'd6, 32'h01020304);
      add_wr(1, 3'd7, 32'h05060708);
      add_wr(1, 3'd0, 32'h090A0B0C);
      add_wr(1, 3'd1, 32'h0D0E0F10);
      vt[2].b[0] = 8'h40; vt[2].nb = 1;
      add_wr(2, 3'd6, 32'h00000000);
      add_wr(2, 3'd7, 32'h000000F0);
      vt[3].b[0] = 8'h80; vt[3].b[1] = 8'h0B; vt[3].nb = 2;
      add_wr(3, 3'd7, 32'h0000000B);
      vt[4].b[0] = 8'h0D;
      for (int i = 1; i <= 8; i++) vt[4].b[i] = 8'hA0 + 8'(i);
      vt[4].nb = 9;
      add_wr(4, 3'd5, 32'hA1A2A3A4);
      add_wr(4, 3'd6, 32'hA5A6A7A8);
      set_bytes3(5, 8'hC0, 8'h11, 8'h22, 8'h33, 8'h00, 4);
      vt[5].e_err = 1'b1;
      vt[5].e_done = 0;
`ifdef CHEAT_PGM_CHECKSUM_EN
      for (int v = 0; v < 6; v++) begin
         if (vt[v].b[0][7:6] == 2'b00) begin
            x = 8'h00;
            for (int i = 0; i < vt[v].nb; i++) x = x ^ vt[v].b[i];
            vt[v].b[vt[v].nb] = x;
            vt[v].nb++;
         end
      end
`endif

      bus.frame_start = 1'b0;
      bus.mcu_data    = 8'h00;
      bus.mcu_valid   = 1'b0;
      bus.pgm_block   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'h0, bus.mcu_ready}, 32'h0);
      chk("rst_we",    {31'h0, bus.pgm_we},    32'h0);
      chk("rst_idx",   {29'h0, bus.pgm_idx},   32'h0);
      chk("rst_in",    bus.pgm_in,             32'h0);
      chk("rst_busy",  {31'h0, bus.busy},      32'h0);
      chk("rst_done",  {31'h0, bus.done},      32'h0);
      chk("rst_err",   {31'h0, bus.err},       32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int v = 0; v < 6; v++) begin
         clear_log();
         d0 = done_cnt;
         start_frame();
         for (int i = 0; i < vt[v].nb; i++) send_byte(vt[v].b[i]);
         if (vt[v].e_done != 0) wait_done(d0);
         else repeat (8) @(negedge clk);
         #1;
         chk($sformatf("v%0d_nwrites", v), 32'(w_idx.size()), 32'(vt[v].nw));
         for (int k = 0; k < vt[v].nw && k < w_idx.size(); k++) begin
            chk($sformatf("v%0d_idx%0d", v, k), {29'h0, w_idx[k]}, {29'h0, vt[v].ei[k]});
            chk($sformatf("v%0d_data%0d", v, k), w_dat[k], vt[v].ed[k]);
         end
         chk($sformatf("v%0d_err", v), {31'h0, bus.err}, {31'h0, vt[v].e_err});
         chk($sformatf("v%0d_done", v), 32'(done_cnt - d0), 32'(vt[v].e_done));
         chk($sformatf("v%0d_busy", v), {31'h0, bus.busy}, (vt[v].e_done != 0) ? 32'h0 : 32'h1);
         if (vt[v].e_err) chk($sformatf("v%0d_skip_ready", v), {31'h0, bus.mcu_ready}, 32'h1);
         $display("vector %0d: %0d bytes, %0d writes seen, err=%0b busy=%0b", v, vt[v].nb,
                  w_idx.size(), bus.err, bus.busy);
      end

      // err from the invalid-opcode frame is cleared by the next frame_start
      start_frame();
      @(negedge clk);
      chk("err_cleared", {31'h0, bus.err}, 32'h0);
      $display("err clear: err=%0b", bus.err);

      // pending write held while pgm_block is high
      clear_log();
      d0 = done_cnt;
      start_frame();
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
`ifdef CHEAT_PGM_CHECKSUM_EN
      send_byte(8'h44);
      bus.pgm_block = 1'b1;
      send_byte(8'h44);
`else
      bus.pgm_block = 1'b1;
      send_byte(8'h44);
`endif
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("blk_we%0d", c), {31'h0, bus.pgm_we}, 32'h0);
         chk($sformatf("blk_ready%0d", c), {31'h0, bus.mcu_ready}, 32'h0);
      end
      @(posedge clk); #1;
      bus.pgm_block = 1'b0;
      @(negedge clk);
      chk("blk_release_we", {31'h0, bus.pgm_we}, 32'h1);
      chk("blk_release_idx", {29'h0, bus.pgm_idx}, 32'h0);
      chk("blk_release_data", bus.pgm_in, 32'h11223344);
      wait_done(d0);
      chk("blk_nwrites", 32'(w_idx.size()), 32'h1);
      $display("block: %0d writes seen, done=%0d", w_idx.size(), done_cnt - d0);

      // abort mid-word; frame_start with mcu_valid must not consume the byte
      clear_log();
      start_frame();
      send_byte(8'h00);
      send_byte(8'hAA);
      send_byte(8'hBB);
      d0 = done_cnt;
      @(posedge clk); #1;
      bus.frame_start = 1'b1;
      bus.mcu_valid   = 1'b1;
      bus.mcu_data    = 8'h80;
      @(negedge clk);
      chk("abort_ready_low", {31'h0, bus.mcu_ready}, 32'h0);
      @(posedge clk); #1;
      bus.frame_start = 1'b0;
      send_byte(8'h80);
      send_byte(8'h5A);
      wait_done(d0);
      chk("abort_nwrites", 32'(w_idx.size()), 32'h1);
      if (w_idx.size() > 0) begin
         chk("abort_idx", {29'h0, w_idx[0]}, 32'h7);
         chk("abort_data", w_dat[0], 32'h0000005A);
      end
      chk("abort_done", 32'(done_cnt - d0), 32'h1);
      $display("abort: %0d writes seen, done=%0d", w_idx.size(), done_cnt - d0);

`ifdef CHEAT_PGM_CHECKSUM_EN
      clear_log();
      d0 = done_cnt;
      start_frame();
      send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
      send_byte(8'h00);
      wait_done(d0);
      chk("cks_ok_nwrites", 32'(w_idx.size()), 32'h1);
      if (w_idx.size() > 0) begin
         chk("cks_ok_idx", {29'h0, w_idx[0]}, 32'h0);
         chk("cks_ok_data", w_dat[0], 32'hAABBCCDD);
      end
      $display("checksum ok: %0d writes seen", w_idx.size());

      clear_log();
      d0 = done_cnt;
      start_frame();
      send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
      send_byte(8'h01);
      repeat (8) @(negedge clk);
      #1;
      chk("cks_bad_nwrites", 32'(w_idx.size()), 32'h0);
      chk("cks_bad_err", {31'h0, bus.err}, 32'h1);
      chk("cks_bad_busy", {31'h0, bus.busy}, 32'h0);
      chk("cks_bad_done", 32'(done_cnt - d0), 32'h0);
      $display("checksum bad: %0d writes seen, err=%0b", w_idx.size(), bus.err);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
